dmem_bridge: RTL and testbench

Load/store bridge between the core's data port and a word-addressed synchronous data SRAM. It accepts one byte, half or word request at a time over a valid/ready handshake. It lane-aligns store data and byte enables by address offset, issues a single registered SRAM command, and right-justifies load data. Misaligned or malformed requests are rejected with an error response and never reach memory; sign/zero extension remains in the core.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_align.sv | 30 +++
 rtl/dmem_bridge.sv | 168 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory load/store bridge.
//   - dmem_state_e    : bridge sequencing states
//   - BE_B/BE_H/BE_W  : low-justified size codes carried on the request byte-enable field
//   - is_misaligned() : flags malformed size codes and size/offset combinations
//                       that would straddle a word boundary
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dmem_state_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // A byte fits at any offset, a half only on even offsets, a word only at offset 0.
    // Any other size code is treated as an error as well.
    function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] off);
        logic bad;
        case (be)
            BE_B:    bad = 1'b0;
            BE_H:    bad = off[0];
            BE_W:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: purely combinational lane steering for the bridge.
//   Store side: shifts the low-justified size code and store data up to the byte
//               lane selected by the address offset.
//   Load side : shifts the raw SRAM word down by the captured offset and masks it
//               to the captured access size so upper bits read as zero.
// Ports:
//   st_off_i, st_size_i, st_data_i -> st_be_o, st_data_o   (store alignment)
//   ld_off_i, ld_size_i, ld_raw_i  -> ld_data_o             (load justification)
module dmem_align (
    input  logic [1:0]  st_off_i,
    input  logic [3:0]  st_size_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  ld_off_i,
    input  logic [3:0]  ld_size_i,
    input  logic [31:0] ld_raw_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_mask_s;

    // The size code is a thermometer of enabled bytes, so each bit widens to one byte of mask.
    assign ld_mask_s = {{8{ld_size_i[3]}}, {8{ld_size_i[2]}}, {8{ld_size_i[1]}}, {8{ld_size_i[0]}}};

    assign st_be_o   = st_size_i << st_off_i;
    assign st_data_o = st_data_i << {st_off_i, 3'b000};
    assign ld_data_o = (ld_raw_i >> {ld_off_i, 3'b000}) & ld_mask_s;

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: load/store bridge between the core data port and a word-addressed
// synchronous SRAM. One request at a time; every output is registered.
// Ports:
//   clk, rst (sync, active-high), clk_en (freezes all state when low)
//   i_req_*      : request handshake (valid/write/addr/wdata/size code), o_req_ready
//   o_rsp_*      : one-state response (valid, right-justified rdata, err)
//   o_mem_*      : SRAM command (en/we/word addr/lane be/lane wdata), i_mem_rdata
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31,
    parameter int MEM_AW     = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_req_valid,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH:0]   i_req_addr,
    input  logic [DATA_WIDTH:0]   i_req_wdata,
    input  logic [3:0]            i_req_be,
    output logic                  o_req_ready,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH:0]   o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [MEM_AW-1:0]     o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [DATA_WIDTH:0]   o_mem_wdata,
    input  logic [DATA_WIDTH:0]   i_mem_rdata
);

    dmem_state_e         state_q;
    logic                ready_q;
    logic [1:0]          off_q;
    logic [3:0]          size_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [DATA_WIDTH:0] mem_wdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_WIDTH:0] rsp_rdata_q;

    logic                hs_s;
    logic                bad_s;
    logic [3:0]          st_be_s;
    logic [DATA_WIDTH:0] st_data_s;
    logic [DATA_WIDTH:0] ld_data_s;
    logic                unused_addr_s;

    // Address bits above the SRAM window are intentionally dropped.
    assign unused_addr_s = ^i_req_addr[ADDR_WIDTH:MEM_AW+2];

    assign hs_s  = i_req_valid & ready_q;
    assign bad_s = is_misaligned(i_req_be, i_req_addr[1:0]);

    dmem_align u_align (
        .st_off_i  (i_req_addr[1:0]),
        .st_size_i (i_req_be),
        .st_data_i (i_req_wdata),
        .ld_off_i  (off_q),
        .ld_size_i (size_q),
        .ld_raw_i  (i_mem_rdata),
        .st_be_o   (st_be_s),
        .st_data_o (st_data_s),
        .ld_data_o (ld_data_s)
    );

    // Bridge sequencer: state plus every registered output. Reset overrides clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        ready_q <= 1'b0;
                        off_q   <= i_req_addr[1:0];
                        size_q  <= i_req_be;
                        if (bad_s) begin
                            // Rejected requests skip memory entirely.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_CMD;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= i_req_write;
                            mem_addr_q  <= i_req_addr[MEM_AW+1:2];
                            mem_be_q    <= st_be_s;
                            mem_wdata_q <= st_data_s;
                        end
                    end else begin
                        // Also raises ready on the first advance after reset.
                        ready_q <= 1'b1;
                    end
                end
                ST_CMD: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_be_q    <= 4'd0;
                    mem_wdata_q <= '0;
                    if (mem_we_q) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= ld_data_s;
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_be_q    <= 4'd0;
                    mem_wdata_q <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed requests, a latency/lane model
// counted in advances, a bench-side SRAM, and literal spot checks.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        i_req_valid;
    logic        i_req_write;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [13:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    dmem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .i_req_valid (i_req_valid),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_be    (i_req_be),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench SRAM: clocked every edge, independent of clk_en.
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (o_mem_be[i]) sram[o_mem_addr[7:0]][8*i +: 8] <= o_mem_wdata[8*i +: 8];
            end else begin
                i_mem_rdata <= sram[o_mem_addr[7:0]];
            end
        end
    end

    // Reference model: a transaction's outputs are a function of how many advances
    // have happened since its handshake (cmd at 1, response at its latency).
    logic [31:0] ref_mem [256];
    bit          m_init = 0;
    bit          m_seen = 0;
    bit          m_busy = 0;
    int          m_adv  = 0;
    int          m_lat  = 0;
    int          m_kind = 0;   // 0 store, 1 load, 2 rejected
    logic [13:0] m_waddr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic [31:0] m_rd;

    task automatic model_accept();
        int off;
        int nb;
        logic [63:0] w;
        logic [7:0]  idx;
        off = int'(i_req_addr[1:0]);
        nb  = (i_req_be == 4'b0001) ? 1 : (i_req_be == 4'b0011) ? 2 : (i_req_be == 4'b1111) ? 4 : 0;
        idx = i_req_addr[9:2];
        m_waddr = 14'(i_req_addr >> 2);
        m_rd = 32'd0;
        m_be = 4'd0;
        m_wd = 32'd0;
        if (nb == 0 || (off % nb) != 0) begin
            m_kind = 2;
            m_lat  = 1;
        end else begin
            m_be = 4'(int'(i_req_be) * (2 ** off));
            w    = 64'(i_req_wdata) << (8 * off);
            m_wd = w[31:0];
            if (i_req_write) begin
                m_kind = 0;
                m_lat  = 2;
                for (int i = 0; i < nb; i++)
                    ref_mem[idx][8*(off+i) +: 8] = i_req_wdata[8*i +: 8];
            end else begin
                m_kind = 1;
                m_lat  = 3;
                w      = (64'(ref_mem[idx]) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
                m_rd   = w[31:0];
            end
        end
        m_adv  = 1;
        m_busy = 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_seen = 0;
            m_busy = 0;
        end else if (clk_en) begin
            if (m_busy) begin
                m_adv++;
                if (m_adv > m_lat) m_busy = 0;
            end else if (m_seen && i_req_valid) begin
                model_accept();
            end
            m_seen = 1;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        bit e_cmd;
        bit e_rsp;
        if (m_init) begin
            e_cmd = m_busy && m_kind != 2 && m_adv == 1;
            e_rsp = m_busy && m_adv == m_lat;
            chk("ready",     32'(o_req_ready), 32'(!m_busy && m_seen));
            chk("mem_en",    32'(o_mem_en),    32'(e_cmd));
            chk("mem_we",    32'(o_mem_we),    32'(e_cmd && m_kind == 0));
            chk("mem_addr",  32'(o_mem_addr),  e_cmd ? 32'(m_waddr) : 32'd0);
            chk("mem_be",    32'(o_mem_be),    e_cmd ? 32'(m_be) : 32'd0);
            chk("mem_wdata", o_mem_wdata,      e_cmd ? m_wd : 32'd0);
            chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rsp));
            chk("rsp_err",   32'(o_rsp_err),   32'(e_rsp && m_kind == 2));
            chk("rsp_rdata", o_rsp_rdata,      e_rsp ? m_rd : 32'd0);
        end
    end

    // Called at a negedge; handshake happens at the following posedge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_be    = be;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        sram[0]     = 32'h0000AB00;
        ref_mem[0]  = 32'h0000AB00;
        i_mem_rdata = 32'd0;
        rst         = 1'b1;
        clk_en      = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = 32'd0;
        i_req_wdata = 32'd0;
        i_req_be    = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("lit_rst_ready", 32'(o_req_ready), 32'd0);
        chk("lit_rst_mem_en", 32'(o_mem_en), 32'd0);
        chk("lit_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_ready_after_rst", 32'(o_req_ready), 32'd1);

        // Store word 0xDEADBEEF to 0x100
        issue(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
        @(negedge clk);
        chk("lit_sw_en", 32'(o_mem_en), 32'd1);
        chk("lit_sw_we", 32'(o_mem_we), 32'd1);
        chk("lit_sw_addr", 32'(o_mem_addr), 32'h40);
        chk("lit_sw_be", 32'(o_mem_be), 32'hF);
        chk("lit_sw_wdata", o_mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("lit_sw_rsp", 32'(o_rsp_valid), 32'd1);
        chk("lit_sw_err", 32'(o_rsp_err), 32'd0);
        @(negedge clk);

        // Store byte 0xA5 to 0x103
        issue(1'b1, 32'h103, 32'h000000A5, 4'b0001);
        @(negedge clk);
        chk("lit_sb_addr", 32'(o_mem_addr), 32'h40);
        chk("lit_sb_be", 32'(o_mem_be), 32'h8);
        chk("lit_sb_wdata", o_mem_wdata, 32'hA5000000);
        @(negedge clk);

        // Store half to 0x002, then word 0x1234ABCD to 0x100
        issue(1'b1, 32'h002, 32'h00007766, 4'b0011);
        @(negedge clk);
        chk("lit_sh_be", 32'(o_mem_be), 32'hC);
        chk("lit_sh_wdata", o_mem_wdata, 32'h77660000);
        @(negedge clk);
        issue(1'b1, 32'h100, 32'h1234ABCD, 4'b1111);
        @(negedge clk);

        // Load half from 0x102
        issue(1'b0, 32'h102, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        chk("lit_lh_en", 32'(o_mem_en), 32'd1);
        chk("lit_lh_we", 32'(o_mem_we), 32'd0);
        @(negedge clk);
        chk("lit_lh_norsp", 32'(o_rsp_valid), 32'd0);
        @(negedge clk);
        chk("lit_lh_rsp", 32'(o_rsp_valid), 32'd1);
        chk("lit_lh_rdata", o_rsp_rdata, 32'h00001234);
        chk("lit_lh_err", 32'(o_rsp_err), 32'd0);
        @(negedge clk);

        // Load word from 0x101 (rejected); a request while not ready is ignored
        issue(1'b0, 32'h101, 32'd0, 4'b1111);
        @(negedge clk);
        chk("lit_lw_err_rsp", 32'(o_rsp_valid), 32'd1);
        chk("lit_lw_err", 32'(o_rsp_err), 32'd1);
        chk("lit_lw_err_rdata", o_rsp_rdata, 32'd0);
        chk("lit_lw_err_en", 32'(o_mem_en), 32'd0);
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_addr  = 32'h200;
        i_req_wdata = 32'h55555555;
        i_req_be    = 4'b1111;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);

        // Store half to 0x101 (rejected), then a malformed size code
        issue(1'b1, 32'h101, 32'hBEEF, 4'b0011);
        @(negedge clk);
        chk("lit_sh_err", 32'(o_rsp_err), 32'd1);
        chk("lit_sh_err_en", 32'(o_mem_en), 32'd0);
        @(negedge clk);
        issue(1'b1, 32'h000, 32'h1, 4'b0111);
        @(negedge clk);
        chk("lit_bad_be_err", 32'(o_rsp_err), 32'd1);
        @(negedge clk);

        // Load byte from 0x001 with clk_en low for 3 cycles in WAIT
        issue(1'b0, 32'h001, 32'd0, 4'b0001);
        @(negedge clk);
        chk("lit_lb_en", 32'(o_mem_en), 32'd1);
        @(negedge clk);
        clk_en = 1'b0;
        @(negedge clk);
        chk("lit_lb_frozen", 32'(o_rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        chk("lit_lb_rsp", 32'(o_rsp_valid), 32'd1);
        chk("lit_lb_rdata", o_rsp_rdata, 32'h000000AB);
        @(negedge clk);

        // Reset during CMD of a load
        issue(1'b0, 32'h100, 32'd0, 4'b1111);
        @(negedge clk);
        chk("lit_rl_en", 32'(o_mem_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rl_en_off", 32'(o_mem_en), 32'd0);
        chk("lit_rl_ready", 32'(o_req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rl_ready_back", 32'(o_req_ready), 32'd1);
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
